// File: rtl/decoder_pkg.sv
// Shared field layout, opcode type and default format masks
// for the instruction decoder.
package decoder_pkg;

    localparam int INSTR_W  = 32;
    localparam int OP_POS   = 0;
    localparam int OP_W     = 4;
    localparam int COND_POS = 4;
    localparam int RVD_POS  = 5;
    localparam int RVS_POS  = 6;
    localparam int RND_POS  = 7;
    localparam int RNSA_POS = 10;
    localparam int RNSB_POS = 13;
    localparam int RN_W     = 3;
    localparam int IMM_POS  = 15;
    localparam int IMM_W    = 17;

    localparam logic [15:0] IMM_MASK_DEF     = 16'h00F0;
    localparam logic [15:0] ILLEGAL_MASK_DEF = 16'hF000;

    typedef enum logic [OP_W-1:0] {
        OP_0,  OP_1,  OP_2,  OP_3,
        OP_4,  OP_5,  OP_6,  OP_7,
        OP_8,  OP_9,  OP_10, OP_11,
        OP_12, OP_13, OP_14, OP_15
    } opcode_e;

    typedef struct packed {
        opcode_e          op;
        logic             cond;
        logic             rvd;
        logic             rvs;
        logic [RN_W-1:0]  rnd;
        logic [RN_W-1:0]  rnsa;
        logic [RN_W-1:0]  rnsb;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } fields_t;

endpackage

// File: rtl/decoder_fields.sv
// Combinational field extraction; instruction bit 0 is the MSB.
// Immediate-format ops reuse bit 15 as the top of Imm, so RnSB is zeroed.
module decoder_fields
    import decoder_pkg::*;
#(
    parameter logic [15:0] IMM_MASK     = IMM_MASK_DEF,
    parameter logic [15:0] ILLEGAL_MASK = ILLEGAL_MASK_DEF
) (
    input  logic [0:INSTR_W-1] instr_i,
    output fields_t            fields_o
);

    opcode_e op;
    logic    is_imm;
    logic    is_ill;

    assign op     = opcode_e'(instr_i[OP_POS +: OP_W]);
    assign is_imm = IMM_MASK[op];
    assign is_ill = ILLEGAL_MASK[op];

    always_comb begin
        fields_o         = '0;
        fields_o.op      = op;
        fields_o.cond    = instr_i[COND_POS] & ~is_ill;
        fields_o.rvd     = instr_i[RVD_POS] & ~is_ill;
        fields_o.rvs     = instr_i[RVS_POS];
        fields_o.rnd     = instr_i[RND_POS +: RN_W];
        fields_o.rnsa    = instr_i[RNSA_POS +: RN_W];
        fields_o.illegal = is_ill;
        if (is_imm) begin
            fields_o.imm  = instr_i[IMM_POS +: IMM_W];
        end else begin
            fields_o.rnsb = instr_i[RNSB_POS +: RN_W];
        end
    end

endmodule

// File: rtl/decoder_unit.sv
// Registered instruction decoder: one-cycle latency, stall on en=0,
// bubbles clear out_valid but keep the last decoded fields.
module decoder_unit
    import decoder_pkg::*;
#(
    parameter logic [15:0] IMM_MASK     = IMM_MASK_DEF,
    parameter logic [15:0] ILLEGAL_MASK = ILLEGAL_MASK_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [0:INSTR_W-1]  Instr,
    output logic                out_valid,
    output logic [OP_W-1:0]     op,
    output logic                cond,
    output logic                RvD,
    output logic                RvS,
    output logic [RN_W-1:0]     RnD,
    output logic [RN_W-1:0]     RnSA,
    output logic [RN_W-1:0]     RnSB,
    output logic [IMM_W-1:0]    Imm,
    output logic                illegal
);

    fields_t dec;
    fields_t fields_d;
    fields_t fields_q;
    logic    valid_d;
    logic    valid_q;

    decoder_fields #(
        .IMM_MASK     (IMM_MASK),
        .ILLEGAL_MASK (ILLEGAL_MASK)
    ) u_fields (
        .instr_i  (Instr),
        .fields_o (dec)
    );

    always_comb begin
        fields_d = fields_q;
        valid_d  = valid_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                fields_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fields_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            fields_q <= fields_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign op        = fields_q.op;
    assign cond      = fields_q.cond;
    assign RvD       = fields_q.rvd;
    assign RvS       = fields_q.rvs;
    assign RnD       = fields_q.rnd;
    assign RnSA      = fields_q.rnsa;
    assign RnSB      = fields_q.rnsb;
    assign Imm       = fields_q.imm;
    assign illegal   = fields_q.illegal;

endmodule

// File: tb/tb_decoder_unit.sv
// Scoreboard bench for decoder_unit: a reference model predicts each
// cycle's outputs, expectations are queued at drive and popped at sample.
module tb_decoder_unit;

    localparam logic [15:0] M_IMM = 16'h00F0;
    localparam logic [15:0] M_ILL = 16'hF000;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic        c;
        logic        rvd;
        logic        rvs;
        logic [2:0]  rnd;
        logic [2:0]  rnsa;
        logic [2:0]  rnsb;
        logic [16:0] imm;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [0:31] Instr;
    logic        out_valid;
    logic [3:0]  op;
    logic        cond;
    logic        RvD;
    logic        RvS;
    logic [2:0]  RnD;
    logic [2:0]  RnSA;
    logic [2:0]  RnSB;
    logic [16:0] Imm;
    logic        illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mdl;
    exp_t sb[$];

    decoder_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .Instr     (Instr),
        .out_valid (out_valid),
        .op        (op),
        .cond      (cond),
        .RvD       (RvD),
        .RvS       (RvS),
        .RnD       (RnD),
        .RnSA      (RnSA),
        .RnSB      (RnSB),
        .Imm       (Imm),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t e;
        logic imm_f;
        logic ill_f;
        e     = '0;
        e.op  = w[31:28];
        imm_f = M_IMM[e.op];
        ill_f = M_ILL[e.op];
        e.c   = ill_f ? 1'b0 : w[27];
        e.rvd = ill_f ? 1'b0 : w[26];
        e.rvs = w[25];
        e.rnd = w[24:22];
        e.rnsa = w[21:19];
        e.rnsb = imm_f ? 3'd0 : w[18:16];
        e.imm  = imm_f ? w[16:0] : 17'd0;
        e.ill  = ill_f;
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(out_valid), 32'(e.v));
        check({tag, ".op"}, 32'(op), 32'(e.op));
        check({tag, ".cond"}, 32'(cond), 32'(e.c));
        check({tag, ".RvD"}, 32'(RvD), 32'(e.rvd));
        check({tag, ".RvS"}, 32'(RvS), 32'(e.rvs));
        check({tag, ".RnD"}, 32'(RnD), 32'(e.rnd));
        check({tag, ".RnSA"}, 32'(RnSA), 32'(e.rnsa));
        check({tag, ".RnSB"}, 32'(RnSB), 32'(e.rnsb));
        check({tag, ".Imm"}, 32'(Imm), 32'(e.imm));
        check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    endtask

    task automatic drive(input string tag, input logic r, input logic e,
                         input logic v, input logic [31:0] w);
        exp_t d;
        exp_t got_e;
        rst_n    = r;
        en       = e;
        in_valid = v;
        Instr    = w;
        if (!r) begin
            mdl = '0;
        end else if (e) begin
            if (v) begin
                d   = model_dec(w);
                d.v = 1'b1;
                mdl = d;
            end else begin
                mdl.v = 1'b0;
            end
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb.pop_front();
            cmp(tag, got_e);
        end
    endtask

    localparam logic [31:0] I_REG = 32'b00001010000110100110000010000000;
    localparam logic [31:0] I_IMM = 32'b01100010110110100000010000100000;
    localparam logic [31:0] I_ILL = 32'hFFFF_FFFF;

    initial begin
        exp_t lr;
        exp_t li;
        exp_t ll;
        exp_t lb;
        lr = '{v:1, op:0, c:1, rvd:0, rvs:1, rnd:0, rnsa:3, rnsb:2,
               imm:0, ill:0};
        li = '{v:1, op:6, c:0, rvd:0, rvs:1, rnd:3, rnsa:3, rnsb:0,
               imm:17'h00420, ill:0};
        ll = '{v:1, op:15, c:0, rvd:0, rvs:1, rnd:7, rnsa:7, rnsb:7,
               imm:0, ill:1};
        mdl = '0;

        drive("rst0", 1'b0, 1'b1, 1'b1, I_ILL);
        drive("rst1", 1'b0, 1'b1, 1'b1, I_ILL);
        drive("post_rst", 1'b1, 1'b1, 1'b0, I_ILL);
        cmp("post_rst_lit", '0);

        drive("reg", 1'b1, 1'b1, 1'b1, I_REG);
        cmp("reg_lit", lr);
        for (int i = 0; i < 3; i++) begin
            drive("stall", 1'b1, 1'b0, 1'b1, I_IMM);
            cmp("stall_lit", lr);
        end
        drive("imm", 1'b1, 1'b1, 1'b1, I_IMM);
        cmp("imm_lit", li);
        drive("ill", 1'b1, 1'b1, 1'b1, I_ILL);
        cmp("ill_lit", ll);
        drive("bubble", 1'b1, 1'b1, 1'b0, I_REG);
        lb   = ll;
        lb.v = 1'b0;
        cmp("bubble_lit", lb);
        drive("stall_inv", 1'b1, 1'b0, 1'b1, I_REG);
        cmp("stall_inv_lit", lb);

        for (int i = 0; i < 16; i++) begin
            drive("b2b", 1'b1, 1'b1, 1'b1, {4'(i), 28'($urandom)});
        end
        for (int i = 0; i < 60; i++) begin
            drive("rand", 1'b1, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), $urandom);
        end
        drive("rst_en0", 1'b0, 1'b0, 1'b1, I_REG);
        cmp("rst_en0_lit", '0);
        drive("after", 1'b1, 1'b1, 1'b1, I_IMM);
        cmp("after_lit", li);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_unit.md
DECODER_UNIT -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter IMM_MASK, default 16'h00F0, SHALL mean that bit k set makes opcode k immediate-format.
REQ-003 Parameter ILLEGAL_MASK, default 16'hF000, SHALL mean that bit k set makes opcode k illegal.
REQ-004 The ports SHALL be exactly these, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance enable; 0 = stall, hold all outputs
- in_valid  in  1  Instr is valid this cycle
- Instr  in  [0:31]  instruction; bit 0 is the MSB
- out_valid  out  1  decoded fields are valid
- op  out  4  opcode
- cond  out  1  conditional-execute flag
- RvD  out  1  destination is a vector register
- RvS  out  1  sources are vector registers
- RnD  out  3  destination register number
- RnSA  out  3  source A register number
- RnSB  out  3  source B register number
- Imm  out  17  immediate
- illegal  out  1  opcode flagged illegal

Function
REQ-005 Field extraction SHALL be: op=Instr[0:3], cond=Instr[4], RvD=Instr[5], RvS=Instr[6], RnD=Instr[7:9], RnSA=Instr[10:12]; index 0 is the MSB of each field.
REQ-006 For a register-format op (IMM_MASK[op]=0), the decoder SHALL output RnSB=Instr[13:15] and Imm=0.
REQ-007 For an immediate-format op (IMM_MASK[op]=1), the decoder SHALL output Imm=Instr[15:31] and RnSB=0.
REQ-008 The decoder SHALL set illegal=ILLEGAL_MASK[op].
- An illegal op SHALL still assert out_valid.
- An illegal op SHALL force cond=0 and RvD=0.
- All other fields SHALL decode as normal.
REQ-009 All outputs SHALL be registered, with a latency of 1 cycle from a sampled Instr.
REQ-010 When en=1, each rising edge SHALL load the decode of Instr and set out_valid=in_valid.
REQ-011 When en=1 and in_valid=0, the decoder SHALL clear out_valid and hold all field outputs at their previous values.
REQ-012 When en=0, all outputs SHALL hold, regardless of in_valid or Instr.
REQ-013 Back-to-back valid instructions SHALL produce back-to-back valid outputs, one per cycle, with no bubble.

Reset
REQ-014 When rst_n=0 at a rising edge, every output SHALL be 0: out_valid, op, cond, RvD, RvS, RnD, RnSA, RnSB, Imm and illegal.
REQ-015 Reset SHALL override en.
REQ-016 An instruction presented in the reset cycle SHALL be dropped.

Structure
REQ-017 Package decoder_pkg SHALL hold:
- field position and width constants;
- the opcode typedef (4-bit enum OP_0..OP_15);
- the default IMM_MASK and ILLEGAL_MASK values.
REQ-018 Combinational field extraction SHALL live in one sub-module, decoder_fields.
REQ-019 The decoder top SHALL contain only the output registers and the enable/valid logic.

Verification
REQ-020 Reset: hold rst_n=0 for 2 cycles, then release -> every output reads 0 in the cycle after release.
REQ-021 Register format: Instr=32'b00001010000110100110000010000000, in_valid=1, en=1 -> next cycle op=0, cond=1, RvD=0, RvS=1, RnD=0, RnSA=3, RnSB=2, Imm=0, illegal=0, out_valid=1.
REQ-022 Immediate format: Instr=32'b01100010110110100000010000100000 -> next cycle op=6, cond=0, RvD=0, RvS=1, RnD=3, RnSA=3, RnSB=0, Imm=17'h00420, illegal=0.
REQ-023 Stall: apply REQ-021, then en=0 with REQ-022's Instr for 3 cycles -> outputs unchanged from REQ-021; en=1 -> REQ-022 values appear one cycle later.
REQ-024 Illegal: Instr=32'hFFFF_FFFF -> op=15, illegal=1, cond=0, RvD=0, RvS=1, RnD=7, RnSA=7, RnSB=7, Imm=0, out_valid=1.
REQ-025 Bubble: in_valid=0 after a valid instruction -> out_valid=0 and all fields keep their prior values.
